// File: rtl/board_write_engine.sv
// Board RAM write-port driver: fills the starting position one square per clock
// and performs range-checked two-write piece moves behind a start/busy/done handshake.
module board_write_engine #(
  parameter int BOARD_DIM = 8,
  parameter int PIECE_W = 4,
  localparam int COORD_W = $clog2(BOARD_DIM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init_start,
  input  logic               move_start,
  input  logic [COORD_W-1:0] piece_x,
  input  logic [COORD_W-1:0] piece_y,
  input  logic [COORD_W-1:0] move_x,
  input  logic [COORD_W-1:0] move_y,
  input  logic [PIECE_W-1:0] piece_to_move,
  output logic               wr_en,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [PIECE_W-1:0] wr_data,
  output logic               busy,
  output logic               init_done,
  output logic               move_done,
  output logic               move_err,
  output logic               board_ready
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INIT     = 3'd1;
  localparam logic [2:0] S_MOVE_DST = 3'd2;
  localparam logic [2:0] S_MOVE_SRC = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [COORD_W:0]   DIM_C   = (COORD_W+1)'(BOARD_DIM);
  localparam logic [COORD_W-1:0] LAST_C  = COORD_W'(BOARD_DIM - 1);
  localparam logic [COORD_W-1:0] WPAWN_C = COORD_W'(BOARD_DIM - 2);
  localparam logic [COORD_W-1:0] ONE_C   = COORD_W'(1);
  localparam logic [COORD_W-1:0] ZERO_C  = COORD_W'(0);

  logic [2:0]         state_r;
  logic [COORD_W-1:0] row_r, col_r;
  logic [COORD_W-1:0] src_x_r, src_y_r, dst_x_r, dst_y_r;
  logic [PIECE_W-1:0] piece_r;
  logic               is_init_r;
  logic               err_r;
  logic               req_bad_s;

  // Starting-position code; back-rank columns past the eighth stay empty for both colours.
  function automatic logic [PIECE_W-1:0] init_code(input logic [COORD_W-1:0] col,
                                                   input logic [COORD_W-1:0] row);
    logic [3:0] rank_s;
    logic [4:0] col_ext_s;
    col_ext_s = 5'(col);
    case (col_ext_s)
      5'd0, 5'd7: rank_s = 4'd4;
      5'd1, 5'd6: rank_s = 4'd2;
      5'd2, 5'd5: rank_s = 4'd3;
      5'd3:       rank_s = 4'd6;
      5'd4:       rank_s = 4'd5;
      default:    rank_s = 4'd0;
    endcase
    if (row == ZERO_C) begin
      return PIECE_W'(rank_s);
    end else if (row == LAST_C) begin
      return (rank_s == 4'd0) ? PIECE_W'(4'd0) : PIECE_W'(rank_s + 4'd6);
    end else if (row == ONE_C) begin
      return PIECE_W'(4'd1);
    end else if (row == WPAWN_C) begin
      return PIECE_W'(4'd7);
    end else begin
      return PIECE_W'(4'd0);
    end
  endfunction

  // Move request validation: range, null move, and an initialised board.
  always_comb begin
    req_bad_s = 1'b0;
    if (({1'b0, piece_x} >= DIM_C) || ({1'b0, piece_y} >= DIM_C) ||
        ({1'b0, move_x} >= DIM_C) || ({1'b0, move_y} >= DIM_C)) begin
      req_bad_s = 1'b1;
    end else if ((piece_x == move_x) && (piece_y == move_y)) begin
      req_bad_s = 1'b1;
    end else if (!board_ready) begin
      req_bad_s = 1'b1;
    end else begin
      req_bad_s = 1'b0;
    end
  end

  // Control FSM, init scan counters and move capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      row_r     <= ZERO_C;
      col_r     <= ZERO_C;
      src_x_r   <= ZERO_C;
      src_y_r   <= ZERO_C;
      dst_x_r   <= ZERO_C;
      dst_y_r   <= ZERO_C;
      piece_r   <= {PIECE_W{1'b0}};
      is_init_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (init_start) begin
            state_r   <= S_INIT;
            row_r     <= ZERO_C;
            col_r     <= ZERO_C;
            is_init_r <= 1'b1;
          end else if (move_start) begin
            if (req_bad_s) begin
              err_r <= 1'b1;
            end else begin
              src_x_r   <= piece_x;
              src_y_r   <= piece_y;
              dst_x_r   <= move_x;
              dst_y_r   <= move_y;
              piece_r   <= piece_to_move;
              is_init_r <= 1'b0;
              state_r   <= S_MOVE_DST;
            end
          end
        end
        S_INIT: begin
          if ((col_r == LAST_C) && (row_r == LAST_C)) begin
            state_r <= S_DONE;
          end else if (col_r == LAST_C) begin
            col_r <= ZERO_C;
            row_r <= row_r + ONE_C;
          end else begin
            col_r <= col_r + ONE_C;
          end
        end
        S_MOVE_DST: state_r <= S_MOVE_SRC;
        S_MOVE_SRC: state_r <= S_DONE;
        S_DONE:     state_r <= S_IDLE;
        default:    state_r <= S_IDLE;
      endcase
    end
  end

  // Registered write port and status, one cycle behind the FSM; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en       <= 1'b0;
      wr_x        <= ZERO_C;
      wr_y        <= ZERO_C;
      wr_data     <= {PIECE_W{1'b0}};
      busy        <= 1'b0;
      init_done   <= 1'b0;
      move_done   <= 1'b0;
      move_err    <= 1'b0;
      board_ready <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      init_done <= 1'b0;
      move_done <= 1'b0;
      move_err  <= err_r;
      busy      <= (state_r != S_IDLE);
      case (state_r)
        S_INIT: begin
          wr_en   <= 1'b1;
          wr_x    <= col_r;
          wr_y    <= row_r;
          wr_data <= init_code(col_r, row_r);
        end
        S_MOVE_DST: begin
          wr_en   <= 1'b1;
          wr_x    <= dst_x_r;
          wr_y    <= dst_y_r;
          wr_data <= piece_r;
        end
        S_MOVE_SRC: begin
          wr_en   <= 1'b1;
          wr_x    <= src_x_r;
          wr_y    <= src_y_r;
          wr_data <= {PIECE_W{1'b0}};
        end
        S_DONE: begin
          if (is_init_r) begin
            init_done   <= 1'b1;
            board_ready <= 1'b1;
          end else begin
            move_done <= 1'b1;
          end
        end
        default: wr_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_board_write_engine.sv
// Self-checking bench: cycle-level reference model for an 8x8 engine plus directed
// checks on 10x10 initialisation and 6x6 range rejection.
module tb_board_write_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // 8x8 instance
  logic       reset, init_start, move_start;
  logic [2:0] piece_x, piece_y, move_x, move_y;
  logic [3:0] piece_to_move;
  logic       wr_en;
  logic [2:0] wr_x, wr_y;
  logic [3:0] wr_data;
  logic       busy, init_done, move_done, move_err, board_ready;

  // 10x10 instance
  logic       reset10, init_start10, move_start10;
  logic [3:0] zc10;
  logic [3:0] piece10;
  logic       wr_en10;
  logic [3:0] wr_x10, wr_y10;
  logic [3:0] wr_data10;
  logic       busy10, init_done10, move_done10, move_err10, board_ready10;

  // 6x6 instance
  logic       reset6, init_start6, move_start6;
  logic [2:0] piece_x6, piece_y6, move_x6, move_y6;
  logic [3:0] piece6;
  logic       wr_en6;
  logic [2:0] wr_x6, wr_y6;
  logic [3:0] wr_data6;
  logic       busy6, init_done6, move_done6, move_err6, board_ready6;

  board_write_engine #(.BOARD_DIM(8), .PIECE_W(4)) dut8 (
    .clk(clk), .reset(reset), .init_start(init_start), .move_start(move_start),
    .piece_x(piece_x), .piece_y(piece_y), .move_x(move_x), .move_y(move_y),
    .piece_to_move(piece_to_move), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .busy(busy), .init_done(init_done), .move_done(move_done),
    .move_err(move_err), .board_ready(board_ready));

  board_write_engine #(.BOARD_DIM(10), .PIECE_W(4)) dut10 (
    .clk(clk), .reset(reset10), .init_start(init_start10), .move_start(move_start10),
    .piece_x(zc10), .piece_y(zc10), .move_x(zc10), .move_y(zc10),
    .piece_to_move(piece10), .wr_en(wr_en10), .wr_x(wr_x10), .wr_y(wr_y10),
    .wr_data(wr_data10), .busy(busy10), .init_done(init_done10), .move_done(move_done10),
    .move_err(move_err10), .board_ready(board_ready10));

  board_write_engine #(.BOARD_DIM(6), .PIECE_W(4)) dut6 (
    .clk(clk), .reset(reset6), .init_start(init_start6), .move_start(move_start6),
    .piece_x(piece_x6), .piece_y(piece_y6), .move_x(move_x6), .move_y(move_y6),
    .piece_to_move(piece6), .wr_en(wr_en6), .wr_x(wr_x6), .wr_y(wr_y6),
    .wr_data(wr_data6), .busy(busy6), .init_done(init_done6), .move_done(move_done6),
    .move_err(move_err6), .board_ready(board_ready6));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Chess starting position for a dim x dim board.
  function automatic int start_code(input int dim, input int x, input int y);
    int back [8];
    int r;
    back = '{4, 2, 3, 6, 5, 3, 2, 4};
    r = (x < 8) ? back[x] : 0;
    if (y == 0) return r;
    if (y == dim - 1) return (r == 0) ? 0 : r + 6;
    if (y == 1) return 1;
    if (y == dim - 2) return 7;
    return 0;
  endfunction

  // Reference model of the 8x8 instance: per-cycle schedule of expected outputs.
  localparam int MAXC = 2048;
  bit m_wr [MAXC];
  int m_x [MAXC];
  int m_y [MAXC];
  int m_d [MAXC];
  bit m_busy [MAXC];
  bit m_id [MAXC];
  bit m_md [MAXC];
  bit m_me [MAXC];
  bit m_rs [MAXC];
  int next_ok = 0;
  bit ready_m = 1'b0;
  int lx = 0, ly = 0, ld = 0;
  bit e_wr, e_busy, e_id, e_md, e_me, e_rdy;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (cyc + 70 < MAXC) begin
        if (reset) begin
          for (int c = cyc; c < MAXC; c++) begin
            m_wr[c] = 1'b0; m_busy[c] = 1'b0; m_id[c] = 1'b0;
            m_md[c] = 1'b0; m_me[c] = 1'b0; m_rs[c] = 1'b0;
          end
          ready_m = 1'b0; lx = 0; ly = 0; ld = 0;
          next_ok = cyc + 1;
        end else if (cyc >= next_ok) begin
          if (init_start) begin
            for (int i = 0; i < 64; i++) begin
              m_wr[cyc+1+i] = 1'b1;
              m_x[cyc+1+i] = i % 8;
              m_y[cyc+1+i] = i / 8;
              m_d[cyc+1+i] = start_code(8, i % 8, i / 8);
            end
            for (int c = cyc + 1; c <= cyc + 65; c++) m_busy[c] = 1'b1;
            m_id[cyc+65] = 1'b1;
            m_rs[cyc+65] = 1'b1;
            next_ok = cyc + 66;
          end else if (move_start) begin
            if (ready_m && !(piece_x == move_x && piece_y == move_y) &&
                piece_x < 8 && piece_y < 8 && move_x < 8 && move_y < 8) begin
              m_wr[cyc+1] = 1'b1; m_x[cyc+1] = move_x; m_y[cyc+1] = move_y;
              m_d[cyc+1] = piece_to_move;
              m_wr[cyc+2] = 1'b1; m_x[cyc+2] = piece_x; m_y[cyc+2] = piece_y;
              m_d[cyc+2] = 0;
              for (int c = cyc + 1; c <= cyc + 3; c++) m_busy[c] = 1'b1;
              m_md[cyc+3] = 1'b1;
              next_ok = cyc + 4;
            end else begin
              m_me[cyc+1] = 1'b1;
            end
          end
        end
        if (m_rs[cyc]) ready_m = 1'b1;
        if (m_wr[cyc]) begin
          lx = m_x[cyc]; ly = m_y[cyc]; ld = m_d[cyc];
        end
        e_wr = m_wr[cyc]; e_busy = m_busy[cyc]; e_id = m_id[cyc];
        e_md = m_md[cyc]; e_me = m_me[cyc]; e_rdy = ready_m;
      end
    end
  end

  // Every-cycle comparison of the 8x8 instance against the model.
  initial begin
    logic [15:0] act_v, exp_v;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (cyc + 70 < MAXC) begin
        act_v = {wr_en, wr_x, wr_y, wr_data, busy, init_done, move_done, move_err, board_ready};
        exp_v = {e_wr, 3'(lx), 3'(ly), 4'(ld), e_busy, e_id, e_md, e_me, e_rdy};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL model cyc %0d: got en=%b x=%0d y=%0d d=%0d busy=%b idn=%b mdn=%b err=%b rdy=%b expected en=%b x=%0d y=%0d d=%0d busy=%b idn=%b mdn=%b err=%b rdy=%b",
                   cyc, act_v[15], act_v[14:12], act_v[11:9], act_v[8:5], act_v[4], act_v[3],
                   act_v[2], act_v[1], act_v[0], exp_v[15], exp_v[14:12], exp_v[11:9],
                   exp_v[8:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  // Board images rebuilt from the write ports.
  int board8 [8][8];
  int board10 [10][10];
  int cnt8 = 0, cnt10 = 0, cnt6 = 0;
  initial begin
    for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) board8[y][x] = -1;
    for (int y = 0; y < 10; y++) for (int x = 0; x < 10; x++) board10[y][x] = -1;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin board8[wr_y][wr_x] = int'(wr_data); cnt8++; end
      if (wr_en10 === 1'b1) begin board10[wr_y10][wr_x10] = int'(wr_data10); cnt10++; end
      if (wr_en6 === 1'b1) cnt6++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, at, n0;
    reset = 1'b1; init_start = 1'b0; move_start = 1'b0;
    piece_x = 3'd0; piece_y = 3'd0; move_x = 3'd0; move_y = 3'd0; piece_to_move = 4'd0;
    reset10 = 1'b1; init_start10 = 1'b0; move_start10 = 1'b0; zc10 = 4'd0; piece10 = 4'd0;
    reset6 = 1'b1; init_start6 = 1'b0; move_start6 = 1'b0;
    piece_x6 = 3'd0; piece_y6 = 3'd0; move_x6 = 3'd0; move_y6 = 3'd0; piece6 = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", board_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    reset = 1'b0;
    @(negedge clk);

    // Move before any init is rejected
    piece_x = 3'd1; piece_y = 3'd1; move_x = 3'd2; move_y = 3'd2; piece_to_move = 4'd3;
    move_start = 1'b1;
    @(negedge clk); move_start = 1'b0;
    @(negedge clk);
    chk("noinit_err", move_err, 1);
    chk("noinit_wr", wr_en, 0);
    chk("noinit_busy", busy, 0);
    @(negedge clk);
    chk("noinit_err_pulse", move_err, 0);

    // init and move together, then move_start held during INIT
    n0 = cnt8;
    init_start = 1'b1; move_start = 1'b1;
    piece_x = 3'd0; piece_y = 3'd1; move_x = 3'd0; move_y = 3'd2;
    @(negedge clk); init_start = 1'b0; s = cyc;
    repeat (5) @(negedge clk);
    move_start = 1'b0;
    at = -1;
    for (int k = 0; k < 100 && at < 0; k++) begin
      @(negedge clk);
      if (init_done) at = cyc;
    end
    chk("init_done_edge", at + 1 - s, 66);
    chk("init_writes", cnt8 - n0, 64);
    @(negedge clk);
    chk("init_ready", board_ready, 1);
    chk("sq_0_0", board8[0][0], 4);
    chk("sq_3_0", board8[0][3], 6);
    chk("sq_4_0", board8[0][4], 5);
    chk("sq_3_7", board8[7][3], 12);
    chk("sq_5_1", board8[1][5], 1);
    chk("sq_2_6", board8[6][2], 7);
    chk("sq_4_4", board8[4][4], 0);

    // Null move rejected
    piece_x = 3'd2; piece_y = 3'd2; move_x = 3'd2; move_y = 3'd2;
    move_start = 1'b1;
    @(negedge clk); move_start = 1'b0;
    @(negedge clk);
    chk("null_err", move_err, 1);
    chk("null_wr", wr_en, 0);

    // Legal move; inputs scrambled right after capture
    @(negedge clk);
    piece_x = 3'd4; piece_y = 3'd6; move_x = 3'd4; move_y = 3'd4; piece_to_move = 4'd7;
    move_start = 1'b1;
    @(negedge clk); move_start = 1'b0; s = cyc;
    piece_x = 3'd7; piece_y = 3'd7; move_x = 3'd0; move_y = 3'd0; piece_to_move = 4'd0;
    at = -1;
    for (int k = 0; k < 10 && at < 0; k++) begin
      @(negedge clk);
      if (move_done) at = cyc;
    end
    chk("move_done_cyc", at - s, 3);
    chk("move_dst", board8[4][4], 7);
    chk("move_src", board8[6][4], 0);
    @(negedge clk);

    // Re-init while ready
    n0 = cnt8;
    init_start = 1'b1;
    @(negedge clk); init_start = 1'b0;
    at = -1;
    for (int k = 0; k < 100 && at < 0; k++) begin
      @(negedge clk);
      if (init_done) at = cyc;
    end
    chk("reinit_writes", cnt8 - n0, 64);
    chk("reinit_sq_4_4", board8[4][4], 0);
    chk("reinit_sq_4_6", board8[6][4], 7);
    @(negedge clk);

    // Reset while the origin write is due
    piece_x = 3'd1; piece_y = 3'd6; move_x = 3'd1; move_y = 3'd5; piece_to_move = 4'd7;
    move_start = 1'b1;
    @(negedge clk); move_start = 1'b0;
    @(negedge clk);
    chk("mid_dst_wr", wr_en, 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("mid_rst_wr", wr_en, 0);
    chk("mid_rst_ready", board_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_origin_kept", board8[6][1], 7);
    chk("mid_dst_written", board8[5][1], 7);
    move_start = 1'b1;
    @(negedge clk); move_start = 1'b0;
    @(negedge clk);
    chk("post_rst_err", move_err, 1);

    // 10x10 initialisation
    reset10 = 1'b0;
    @(negedge clk);
    init_start10 = 1'b1;
    @(negedge clk); init_start10 = 1'b0; s = cyc;
    at = -1;
    for (int k = 0; k < 150 && at < 0; k++) begin
      @(negedge clk);
      if (init_done10) at = cyc;
    end
    chk("d10_done_edge", at + 1 - s, 102);
    chk("d10_writes", cnt10, 100);
    chk("d10_sq_8_0", board10[0][8], 0);
    chk("d10_sq_9_9", board10[9][9], 0);
    chk("d10_sq_7_9", board10[9][7], 10);
    for (int x = 0; x < 10; x++) chk($sformatf("d10_row8_x%0d", x), board10[8][x], 7);
    @(negedge clk);
    chk("d10_ready", board_ready10, 1);

    // 6x6 out-of-range destination
    reset6 = 1'b0;
    @(negedge clk);
    init_start6 = 1'b1;
    @(negedge clk); init_start6 = 1'b0;
    at = -1;
    for (int k = 0; k < 60 && at < 0; k++) begin
      @(negedge clk);
      if (init_done6) at = cyc;
    end
    @(negedge clk);
    chk("d6_ready", board_ready6, 1);
    n0 = cnt6;
    piece_x6 = 3'd0; piece_y6 = 3'd1; move_x6 = 3'd6; move_y6 = 3'd1; piece6 = 4'd1;
    move_start6 = 1'b1;
    @(negedge clk); move_start6 = 1'b0;
    @(negedge clk);
    chk("d6_range_err", move_err6, 1);
    chk("d6_busy", busy6, 0);
    @(negedge clk);
    chk("d6_no_writes", cnt6 - n0, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_write_engine.md
# board_write_engine

Parametrised board-update engine that drives the write port of the board memory. It fills an N×N board with the standard starting position, one square per clock. It also executes piece moves as a two-write sequence: write the piece to the destination, then erase the origin. Moves are range-checked, with an explicit start/busy/done handshake. It sits between the game-control FSM and the board RAM; the renderer reads the same RAM independently.

## Interface
Parameters:
- BOARD_DIM, 8: board edge length in squares; legal range 4..16, non-power-of-two allowed.
- PIECE_W, 4: piece code width; minimum 4.
- COORD_W, derived localparam = $clog2(BOARD_DIM): coordinate width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- init_start  in  1  request a full board initialisation.
- move_start  in  1  request a move.
- piece_x, piece_y  in  COORD_W each  origin square.
- move_x, move_y  in  COORD_W each  destination square.
- piece_to_move  in  PIECE_W  code written to the destination.
- wr_en  out  1  board RAM write strobe.
- wr_x, wr_y  out  COORD_W each  write address.
- wr_data  out  PIECE_W  write data.
- busy  out  1  engine is not in IDLE.
- init_done  out  1  one-cycle pulse when initialisation finishes.
- move_done  out  1  one-cycle pulse when a move finishes.
- move_err  out  1  one-cycle pulse when a move request is rejected.
- board_ready  out  1  level: board holds a valid position.

## Operation
- States: IDLE, INIT, MOVE_DST, MOVE_SRC, DONE.
- IDLE:
  - init_start=1 → INIT, with row=col=0.
  - Otherwise move_start=1 → validate the request.
    - Valid: capture all move inputs into registers, then → MOVE_DST.
    - Invalid: pulse move_err next cycle, stay IDLE.
  - init_start wins over move_start when both are asserted.
- Move validation rejects a request when any of these hold:
  - any coordinate ≥ BOARD_DIM;
  - origin equals destination;
  - board_ready=0.
- INIT:
  - Each cycle: wr_en=1, wr_x=col, wr_y=row, wr_data=initial code.
  - col increments, wrapping at BOARD_DIM-1 to 0 with row+1.
  - The write at (BOARD_DIM-1, BOARD_DIM-1) → DONE.
- Initial codes:
  - Empty = 0.
  - Black: pawn 1, knight 2, bishop 3, rook 4, queen 5, king 6.
  - White code = black code + 6.
  - Row 0 is the black back rank; row BOARD_DIM-1 is the white back rank.
  - Back-rank columns 0..7 follow R N B K Q B N R (king at col 3, queen at col 4). Back-rank columns ≥ 8 are empty.
  - Row 1 is black pawns; row BOARD_DIM-2 is white pawns. All other rows are 0.
- MOVE_DST: wr_en=1, write the captured destination with captured piece_to_move → MOVE_SRC.
- MOVE_SRC: wr_en=1, write the captured origin with 0 → DONE.
- DONE:
  - wr_en=0.
  - Pulse init_done or move_done, matching the operation that just finished.
  - After an init: set board_ready=1.
  - → IDLE.
- Requests arriving while busy=1 are ignored: not queued, no error pulse.
- Input changes after capture do not affect an in-flight move.

## Timing
- Reset values: all outputs 0; wr_x/wr_y/wr_data 0; state IDLE; board_ready 0.
- Reset mid-operation aborts immediately. Writes already issued stand; no further writes occur; board_ready clears.
- wr_x/wr_y/wr_data hold their last value while wr_en=0.
- Init latency, start sampled at edge N:
  - Writes occur in cycles N+1 .. N+BOARD_DIM².
  - init_done pulses in cycle N+BOARD_DIM²+1.
  - The next start can be accepted at edge N+BOARD_DIM²+2.
- Move latency, start sampled at edge N:
  - Destination write in cycle N+1, origin write in N+2.
  - move_done pulses in N+3; next start accepted at edge N+4.
- Rejected move: move_err pulses in cycle N+1; busy stays 0.
- busy=1 in INIT, MOVE_DST, MOVE_SRC and DONE.
- Re-init while board_ready=1 is legal. board_ready stays 1 throughout the re-init.

## Test plan
- Reset, init_start pulse, BOARD_DIM=8 → exactly 64 writes in row-major order. (0,0)=4, (3,0)=6, (4,0)=5, (3,7)=12, (5,1)=1, (2,6)=7, (4,4)=0. init_done pulses at cycle 66 relative to the start edge; board_ready=1 afterwards.
- After init, move origin (4,6) → destination (4,4) with piece 7 → write (4,4)←7, then (4,6)←0, move_done one cycle later, move_err stays 0.
- Move before any init, move with origin = destination (2,2)→(2,2), and BOARD_DIM=6 move to x=6 → each gives move_err pulse, no wr_en, busy stays 0.
- init_start and move_start asserted together; then move_start asserted during INIT → init runs alone with no move writes and no error pulse.
- BOARD_DIM=10 init → 100 writes. (8,0)=0, (9,9)=0, (7,9)=10, row 8 all 7, init_done at cycle 102.
- reset asserted in MOVE_SRC cycle → no origin write, all outputs 0 next cycle, board_ready=0, and a subsequent move is rejected.
